div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Execute-stage front end for the RISC-V M-extension divide ops: DIV, DIVU, REM and REMU.
- Resolves the special cases (divide by zero, signed overflow, divisor magnitude ≥ 2^31) in a single cycle.
- All other cases go to the shared iterative divider as non-negative magnitudes only. Large dividends are halved before issue.
- Applies the correction and RISC-V truncating-sign rules, then holds the result for writeback under a valid/ready handshake.

Parameters:
TAG_W, 5, width of the destination-register tag carried alongside the op.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; one clock; reset is asynchronous and active-high
i_valid  in  1  op request from issue
o_ready  out  1  controller can accept an op
i_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
i_rs1  in  32  dividend
i_rs2  in  32  divisor
i_tag  in  TAG_W  destination tag
o_valid  out  1  result available
i_ready  in  1  writeback accepts the result
o_result  out  32  quotient or remainder per i_op
o_tag  out  TAG_W  tag of the result
o_div_valid  out  1  one-cycle start pulse to the divider
o_div_a  out  32  divider dividend, bit31 always 0
o_div_b  out  32  divider divisor, bit31 always 0
i_div_valid  in  1  divider done (level)
i_div_quotient  in  32  divider quotient
i_div_remainder  in  32  divider remainder

Behaviour:
- Reset values: all outputs 0, except o_ready = 1. The state machine goes to IDLE from any state. Reset is shared with the divider and is never applied to this block alone.
- Accept condition: i_valid && o_ready. o_ready = (state == IDLE). Accepting latches op, rs1, rs2 and tag.
- Derived values:
  - sgn = ~op[0]
  - |a| = sgn&&rs1[31] ? -rs1 : rs1, as a 32-bit unsigned value; |b| likewise from rs2
  - negq = sgn & (rs1[31] ^ rs2[31])
  - negr = sgn & rs1[31]
- States: IDLE, FAST, ISSUE, GUARD, WAIT, FIX, DONE.
- IDLE → FAST on accept when any of the following holds. FAST computes qu/ru and goes to FIX the next cycle.
  - rs2 == 0: q = 0xFFFFFFFF, r = rs1 (raw).
  - sgn && rs1 == 0x80000000 && rs2 == 0xFFFFFFFF: q = 0x80000000, r = 0.
  - |b|[31] == 1: qu = (|a| >= |b|), ru = |a| − qu·|b|.
- IDLE → ISSUE otherwise. Set half = |a|[31].
  - o_div_a = half ? |a|>>1 : |a|; o_div_b = |b|.
  - o_div_a and o_div_b are held constant from ISSUE until leaving WAIT.
- ISSUE: o_div_valid = 1 for exactly this cycle → GUARD.
- GUARD: one cycle; i_div_valid is ignored because it may still be high from the previous op → WAIT.
- WAIT: stay until i_div_valid = 1, then capture q' = i_div_quotient, r' = i_div_remainder → FIX.
- FIX:
  - If half: t = {r', a0} (33-bit), ge = (t >= |b|), qu = {q'[30:0], ge}, ru = ge ? t − |b| : t.
  - Else: qu = q', ru = r'.
  - q = negq ? −qu : qu; r = negr ? −ru : ru. The special-case q/r values bypass this sign step.
  - o_result = op[1] ? r : q. Register o_result and o_tag, set o_valid = 1 → DONE.
- DONE: hold o_valid, o_result and o_tag stable until i_ready = 1. On that cycle o_valid drops next edge and state → IDLE; no accept happens in the same cycle.
- Latency, accept to o_valid: fast path 2 cycles; divider path 4 + divider latency.
- i_valid outside IDLE is ignored (no accept), and latched operands are unaffected.
- Reset mid-operation: immediate IDLE, o_div_valid = 0, o_valid = 0, any pending result is discarded.
- All arithmetic is modulo 2^32 except t and its compare, which are 33-bit.

Test Plan:
- DIV rs1 = −7 (0xFFFFFFF9), rs2 = 3 → o_result 0xFFFFFFFE (−2); REM on the same operands → 0xFFFFFFFF (−1); divider sees a = 7, b = 3.
- DIVU 0xFFFFFFFF / 3 → halved issue (a = 0x7FFFFFFF), o_result 0x55555555; REMU on the same operands → 0.
- REM 0x1234 / 0 → o_result 0x1234 and DIV → 0xFFFFFFFF, both 2 cycles after accept, o_div_valid never pulses.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM on the same operands → 0; DIVU 5 / 0x80000001 → 0, and REMU → 5; all on the fast path.
- Hold i_ready = 0 for 10 cycles after o_valid → o_result and o_tag stable, o_ready stays 0; release → IDLE and the next op is accepted.
- Assert i_rst while in WAIT → all outputs at reset values; the next op completes correctly, ignoring stale i_div_valid during GUARD.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Execute-stage front end for DIV/DIVU/REM/REMU: resolves special cases locally,
// issues non-negative magnitudes to the shared iterative divider, fixes up sign and halving.
module div_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_div_valid,
  output logic [31:0]      o_div_a,
  output logic [31:0]      o_div_b,
  input  logic             i_div_valid,
  input  logic [31:0]      i_div_quotient,
  input  logic [31:0]      i_div_remainder
);

  typedef enum logic [2:0] {IDLE, FAST, ISSUE, GUARD, WAIT, FIX, DONE} state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

  function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic sgn);
    return (sgn && v[31]) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] cond_neg(input logic signed [31:0] v, input logic neg);
    return neg ? 32'(-v) : 32'(v);
  endfunction

  state_t state_q, state_d;

  logic             valid_q;
  logic [31:0]      result_q;
  logic [TAG_W-1:0] otag_q;
  logic [31:0]      div_a_q, div_b_q;

  logic [1:0]       op_q;
  logic [31:0]      rs1_q, rs2_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      abs_a_q, abs_b_q;
  logic             half_q, negq_q, negr_q;
  logic [31:0]      qq_q, rq_q;
  logic             bypass_q;

  logic             acc;
  logic             in_sgn, in_fast;
  logic [31:0]      in_abs_a, in_abs_b;

  logic             sgn_q, fast_ovf, fast_ge, fast_byp;
  logic [31:0]      fast_qv, fast_rv;

  logic [32:0]      fix_t;
  logic             fix_ge;
  logic [31:0]      fix_qu, fix_ru, fix_q, fix_r, fix_res;

  // Accept-time classification from the raw request
  always_comb begin
    acc      = i_valid && (state_q == IDLE);
    in_sgn   = ~i_op[0];
    in_abs_a = magnitude(i_rs1, in_sgn);
    in_abs_b = magnitude(i_rs2, in_sgn);
    in_fast  = (i_rs2 == 32'd0) ||
               (in_sgn && (i_rs1 == INT_MIN) && (i_rs2 == ALL_ONE)) ||
               in_abs_b[31];
  end

  // Fast-path quotient/remainder: a divisor magnitude >= 2^31 yields a quotient of 0 or 1
  always_comb begin
    sgn_q    = ~op_q[0];
    fast_ovf = sgn_q && (rs1_q == INT_MIN) && (rs2_q == ALL_ONE);
    fast_ge  = (abs_a_q >= abs_b_q);
    fast_byp = 1'b0;
    fast_qv  = {31'd0, fast_ge};
    fast_rv  = fast_ge ? (abs_a_q - abs_b_q) : abs_a_q;
    if (rs2_q == 32'd0) begin
      fast_byp = 1'b1;
      fast_qv  = ALL_ONE;
      fast_rv  = rs1_q;
    end else if (fast_ovf) begin
      fast_byp = 1'b1;
      fast_qv  = INT_MIN;
      fast_rv  = 32'd0;
    end
  end

  // Undo the pre-issue halving with one restoring step, then apply truncating signs
  always_comb begin
    fix_t  = {rq_q, abs_a_q[0]};
    fix_ge = (fix_t >= {1'b0, abs_b_q});
    fix_qu = qq_q;
    fix_ru = rq_q;
    if (half_q) begin
      fix_qu = {qq_q[30:0], fix_ge};
      fix_ru = fix_ge ? (fix_t[31:0] - abs_b_q) : fix_t[31:0];
    end
    fix_q   = bypass_q ? qq_q : cond_neg(fix_qu, negq_q);
    fix_r   = bypass_q ? rq_q : cond_neg(fix_ru, negr_q);
    fix_res = op_q[1] ? fix_r : fix_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = in_fast ? FAST : ISSUE;
      FAST:    state_d = FIX;
      ISSUE:   state_d = GUARD;
      GUARD:   state_d = WAIT;
      WAIT:    if (i_div_valid) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= 32'd0;
      otag_q   <= '0;
      div_a_q  <= 32'd0;
      div_b_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (acc && !in_fast) begin
        div_a_q <= in_abs_a[31] ? (in_abs_a >> 1) : in_abs_a;
        div_b_q <= in_abs_b;
      end
      if (state_q == FIX) begin
        valid_q  <= 1'b1;
        result_q <= fix_res;
        otag_q   <= tag_q;
      end else if ((state_q == DONE) && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Operand and intermediate datapath registers; qualified by state, no reset needed
  always_ff @(posedge i_clk) begin
    if (acc) begin
      op_q    <= i_op;
      rs1_q   <= i_rs1;
      rs2_q   <= i_rs2;
      tag_q   <= i_tag;
      abs_a_q <= in_abs_a;
      abs_b_q <= in_abs_b;
      half_q  <= in_abs_a[31] & ~in_fast;
      negq_q  <= in_sgn & (i_rs1[31] ^ i_rs2[31]);
      negr_q  <= in_sgn & i_rs1[31];
    end
    if (state_q == FAST) begin
      qq_q     <= fast_qv;
      rq_q     <= fast_rv;
      bypass_q <= fast_byp;
    end else if ((state_q == WAIT) && i_div_valid) begin
      qq_q     <= i_div_quotient;
      rq_q     <= i_div_remainder;
      bypass_q <= 1'b0;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_tag       = otag_q;
  assign o_div_valid = (state_q == ISSUE);
  assign o_div_a     = div_a_q;
  assign o_div_b     = div_b_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural iterative divider that
// keeps its done level (and stale results) asserted into the guard cycle.
module tb_div_issue_ctrl;
  localparam int TAG_W = 5;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [31:0]      i_rs1, i_rs2;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_tag;
  logic             o_div_valid;
  logic [31:0]      o_div_a, o_div_b;
  logic             i_div_valid;
  logic [31:0]      i_div_quotient, i_div_remainder;

  int total = 0;
  int bad   = 0;

  logic [31:0] seen_a, seen_b;
  int          pulses;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_tag(o_tag),
    .o_div_valid(o_div_valid), .o_div_a(o_div_a), .o_div_b(o_div_b),
    .i_div_valid(i_div_valid), .i_div_quotient(i_div_quotient),
    .i_div_remainder(i_div_remainder)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Divider model: done level falls two cycles after the start pulse, rises LAT cycles later
  initial begin
    int k;
    bit busy;
    k = 0; busy = 0; pulses = 0;
    seen_a = 32'd0; seen_b = 32'd1;
    i_div_valid = 1'b1;
    i_div_quotient = 32'hDEAD_BEEF;
    i_div_remainder = 32'hFEED_FACE;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        busy = 0; k = 0;
        i_div_valid = 1'b1;
        i_div_quotient = 32'hBAD0_BAD0;
        i_div_remainder = 32'hBAD1_BAD1;
      end else if (o_div_valid) begin
        busy = 1; k = 0;
        seen_a = o_div_a; seen_b = o_div_b;
        pulses++;
      end else if (busy) begin
        k++;
        if (k == 2) i_div_valid = 1'b0;
        if (k == 2 + LAT) begin
          i_div_valid = 1'b1;
          i_div_quotient = seen_a / seen_b;
          i_div_remainder = seen_a % seen_b;
          busy = 0;
        end
      end
    end
  end

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] exp, input bit fast, input int hold);
    int cyc;
    int p0;
    bit got;
    logic [31:0] r0;
    logic [TAG_W-1:0] t0;
    @(negedge clk);
    check({nm, "_ready"}, {31'd0, o_ready}, 32'd1);
    p0 = pulses;
    i_op = op; i_rs1 = a; i_rs2 = b; i_tag = tag; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    cyc = 0; got = 0;
    while (cyc < 60) begin
      @(negedge clk);
      if (o_valid) begin got = 1; break; end
      @(posedge clk);
      cyc++;
    end
    if (!got) begin
      check({nm, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check(nm, o_result, exp);
    check({nm, "_tag"}, {27'd0, o_tag}, {27'd0, tag});
    if (fast) begin
      check({nm, "_lat"}, cyc, 32'd2);
      check({nm, "_pulses"}, pulses - p0, 32'd0);
    end else begin
      check({nm, "_pulses"}, pulses - p0, 32'd1);
    end
    if (hold > 0) begin
      r0 = o_result; t0 = o_tag;
      i_op = 2'b01; i_rs1 = 32'd99; i_rs2 = 32'd9; i_tag = 5'd31; i_valid = 1'b1;
      repeat (hold) @(negedge clk);
      check({nm, "_hold_res"}, o_result, r0);
      check({nm, "_hold_tag"}, {27'd0, o_tag}, {27'd0, t0});
      check({nm, "_hold_vld"}, {31'd0, o_valid}, 32'd1);
      check({nm, "_hold_rdy"}, {31'd0, o_ready}, 32'd0);
      i_valid = 1'b0;
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({nm, "_drop"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_op = 2'b00; i_rs1 = 32'd0; i_rs2 = 32'd0; i_tag = '0;
    #1;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_divvld", {31'd0, o_div_valid}, 32'd0);
    check("rst_diva", o_div_a, 32'd0);
    repeat (2) @(negedge clk);
    #2 i_rst = 1'b0;

    run_op("div_m7_3", 2'b00, 32'hFFFF_FFF9, 32'd3, 5'd1, 32'hFFFF_FFFE, 0, 0);
    check("div_m7_3_a", seen_a, 32'd7);
    check("div_m7_3_b", seen_b, 32'd3);
    run_op("rem_m7_3", 2'b10, 32'hFFFF_FFF9, 32'd3, 5'd2, 32'hFFFF_FFFF, 0, 0);

    run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'd3, 5'd3, 32'h5555_5555, 0, 0);
    check("divu_big_a", seen_a, 32'h7FFF_FFFF);
    run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'd3, 5'd4, 32'd0, 0, 0);
    run_op("div_min_3", 2'b00, 32'h8000_0000, 32'd3, 5'd5, 32'hD555_5556, 0, 0);
    check("div_min_3_a", seen_a, 32'h4000_0000);
    run_op("rem_min_3", 2'b10, 32'h8000_0000, 32'd3, 5'd6, 32'hFFFF_FFFE, 0, 0);

    run_op("rem_by0", 2'b10, 32'h0000_1234, 32'd0, 5'd7, 32'h0000_1234, 1, 0);
    run_op("div_by0", 2'b00, 32'h0000_1234, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, 0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1, 0);
    run_op("divu_bigb", 2'b01, 32'd5, 32'h8000_0001, 5'd11, 32'd0, 1, 0);
    run_op("remu_bigb", 2'b11, 32'd5, 32'h8000_0001, 5'd12, 32'd5, 1, 0);
    run_op("rem_m1_min", 2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 5'd13, 32'hFFFF_FFFF, 1, 0);
    run_op("div_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 5'd14, 32'd1, 1, 0);

    run_op("hold", 2'b01, 32'd1000, 32'd7, 5'd21, 32'd142, 0, 10);
    run_op("after_hold", 2'b11, 32'd1000, 32'd7, 5'd22, 32'd6, 0, 0);

    // Reset while the divider is busy, then verify a clean restart
    @(negedge clk);
    i_op = 2'b00; i_rs1 = 32'd500; i_rs2 = 32'd3; i_tag = 5'd23; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    check("mid_rst_divvld", {31'd0, o_div_valid}, 32'd0);
    check("mid_rst_result", o_result, 32'd0);
    check("mid_rst_tag", {27'd0, o_tag}, 32'd0);
    check("mid_rst_diva", o_div_a, 32'd0);
    check("mid_rst_divb", o_div_b, 32'd0);
    @(negedge clk);
    #2 i_rst = 1'b0;
    run_op("post_rst_div", 2'b00, 32'd100, 32'd7, 5'd24, 32'd14, 0, 0);
    run_op("post_rst_remu", 2'b11, 32'd100, 32'd7, 5'd25, 32'd2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
